// File: rtl/scan_pkg.sv
// scan_pkg: shared FSM state type, MISR width, tap positions and MISR step function
package scan_pkg;
  localparam int MISR_W = 16;
  localparam int N_TAPS = 4;
  localparam int TAPS [N_TAPS] = '{15, 14, 12, 3};
  typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_CAPTURE, ST_UNLOAD, ST_DONE} state_t;
  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] m, input logic [MISR_W-1:0] d);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < N_TAPS; i++) fb ^= m[TAPS[i]];
    return {m[MISR_W-2:0], fb} ^ d;
  endfunction
endpackage

// File: rtl/scan_misr.sv
// scan_misr: 16-bit MISR (clk, rst, en compacts din, clr zeroes, sig is the state)
module scan_misr
  import scan_pkg::*;
#(
  parameter int N_CHAINS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic [N_CHAINS-1:0] din,
  output logic [MISR_W-1:0]   sig
);
  always_ff @(posedge clk)
    if (rst || clr) sig <= '0;
    else if (en) sig <= misr_next(sig, MISR_W'(din));
endmodule

// File: rtl/scan_seq_ctrl.sv
// scan_seq_ctrl: scan test sequencer (REFCLK/RESET, TESTMODE/START/NUM_PAT control, SI_* pattern stream, SO/SI/SE/SCAN_CE chains, EXP_SIG/SIGNATURE/BUSY/DONE/PASS/ABORT results)
module scan_seq_ctrl
  import scan_pkg::*;
#(
  parameter int N_CHAINS  = 2,
  parameter int CHAIN_LEN = 15,
  parameter int PAT_W     = 8
) (
  input  logic                REFCLK,
  input  logic                RESET,
  input  logic                TESTMODE,
  input  logic                START,
  input  logic [PAT_W-1:0]    NUM_PAT,
  input  logic [N_CHAINS-1:0] SI_DATA,
  input  logic                SI_VALID,
  output logic                SI_READY,
  input  logic [N_CHAINS-1:0] SO,
  output logic [N_CHAINS-1:0] SI,
  output logic                SE,
  output logic                SCAN_CE,
  input  logic [MISR_W-1:0]   EXP_SIG,
  output logic [MISR_W-1:0]   SIGNATURE,
  output logic                BUSY,
  output logic                DONE,
  output logic                PASS,
  output logic                ABORT
);
  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam logic [BW-1:0] LAST = BW'(CHAIN_LEN - 1);
  state_t state, state_nx;
  logic [BW-1:0] beat, beat_nx;
  logic [PAT_W-1:0] pat, pat_nx, pat_inc, num_pat;
  logic abort_q, misr_clr, misr_en, go;
  assign go = START && TESTMODE && state == ST_IDLE;
  assign pat_inc = pat + PAT_W'(1);
  always_comb begin
    state_nx = state;
    beat_nx = beat;
    pat_nx = pat;
    misr_clr = 1'b0;
    SE = 1'b0;
    SCAN_CE = 1'b0;
    SI = '0;
    SI_READY = 1'b0;
    unique case (state)
      ST_IDLE: if (go) begin
        misr_clr = 1'b1;
        beat_nx = '0;
        pat_nx = '0;
        state_nx = NUM_PAT == '0 ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        SE = 1'b1;
        SI_READY = 1'b1;
        SCAN_CE = SI_VALID;
        SI = SI_DATA;
        if (SI_VALID) begin
          beat_nx = beat == LAST ? '0 : beat + BW'(1);
          state_nx = beat == LAST ? ST_CAPTURE : ST_SHIFT;
        end
      end
      ST_CAPTURE: begin
        SCAN_CE = 1'b1;
        pat_nx = pat_inc;
        state_nx = pat_inc < num_pat ? ST_SHIFT : ST_UNLOAD;
      end
      ST_UNLOAD: begin
        SE = 1'b1;
        SCAN_CE = 1'b1;
        beat_nx = beat == LAST ? '0 : beat + BW'(1);
        state_nx = beat == LAST ? ST_DONE : ST_UNLOAD;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (state != ST_IDLE && !TESTMODE) state_nx = ST_IDLE;
  end
  // the first load of a run shifts out uncaptured state, so it is not compacted
  assign misr_en = SCAN_CE && SE && (state == ST_UNLOAD || (state == ST_SHIFT && pat != '0));
  always_ff @(posedge REFCLK)
    if (RESET) begin
      state <= ST_IDLE;
      beat <= '0;
      pat <= '0;
      num_pat <= '0;
      abort_q <= 1'b0;
    end else begin
      state <= state_nx;
      beat <= beat_nx;
      pat <= pat_nx;
      num_pat <= go ? NUM_PAT : num_pat;
      abort_q <= state != ST_IDLE && !TESTMODE;
    end
  scan_misr #(.N_CHAINS(N_CHAINS)) u_misr (
    .clk(REFCLK),
    .rst(RESET),
    .en(misr_en),
    .clr(misr_clr),
    .din(SO),
    .sig(SIGNATURE)
  );
  assign BUSY = state == ST_SHIFT || state == ST_CAPTURE || state == ST_UNLOAD;
  assign DONE = state == ST_DONE && TESTMODE;
  assign PASS = DONE && SIGNATURE == EXP_SIG;
  assign ABORT = abort_q;
endmodule
